// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and default latencies for the pipeline hazard/sequencing controller.
package pipes;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } ctrl_state_t;

  typedef struct packed {
    logic stall;
    logic flush;
  } stage_ctl_t;

  localparam int MUL_LAT_DEF = 3;
  localparam int DIV_LAT_DEF = 64;

endpackage

// File: rtl/pipeline_ctrl_md_timer.sv
// Loadable down-counter timing a multi-cycle mul/div occupying the E stage.
module md_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - W'(1);
    end
  end

  // Asserted on the decrement that lands the count on zero.
  assign zero = (count <= W'(1));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage F/D/E/M/W core: memory waits, mul/div
// occupancy, branch redirects, load-use bubbles and fetch waits.
module pipeline_ctrl import pipes::*; #(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic [4:0] d_rs1,
  input  logic [4:0] d_rs2,
  input  logic       d_use1,
  input  logic       d_use2,
  input  logic       e_valid,
  input  logic [4:0] e_dst,
  input  logic       e_wen,
  input  logic       e_is_load,
  input  logic       e_is_mul,
  input  logic       e_is_div,
  input  logic       e_redirect,
  input  logic       i_req,
  input  logic       i_ack,
  input  logic       m_req,
  input  logic       m_ack,
  output logic       md_start,
  output logic       md_done,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       stall_m,
  output logic       flush_d,
  output logic       flush_e,
  output logic       flush_m,
  output logic       flush_w,
  output logic       redirect_ok
);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

  ctrl_state_t state, state_next;
  logic        md_done_pend, pend_next;
  logic        drop_next, drop_upd;

  logic        mem_wait, md_op, md_launch, lat_one, done_now;
  logic        load_use, fetch_wait, drop_hit, redir, timer_zero;
  logic        f_stall, w_flush;
  stage_ctl_t  d_ctl, e_ctl, m_ctl;

  md_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (md_launch & ~lat_one),
    .load_val (e_is_div ? DIV_LOAD : MUL_LOAD),
    .dec      (state == MD_BUSY),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      md_done_pend <= 1'b0;
      drop_next    <= 1'b0;
    end else begin
      state        <= state_next;
      md_done_pend <= pend_next;
      drop_next    <= drop_upd;
    end
  end

  always_comb begin
    mem_wait   = m_req & ~m_ack;
    md_op      = e_valid & (e_is_mul | e_is_div);
    md_launch  = md_op & (state == RUN) & ~md_done_pend;
    lat_one    = e_is_div ? (DIV_LAT == 1) : (MUL_LAT == 1);
    done_now   = md_done_pend | (lat_one & md_launch);
    load_use   = e_valid & e_is_load & e_wen & (e_dst != 5'd0) & d_valid &
                 ((d_use1 & (d_rs1 == e_dst)) | (d_use2 & (d_rs2 == e_dst)));
    fetch_wait = i_req & ~i_ack;
    drop_hit   = drop_next & i_ack;

    f_stall = 1'b0;
    w_flush = 1'b0;
    d_ctl   = '0;
    e_ctl   = '0;
    m_ctl   = '0;
    redir   = 1'b0;

    // Strict priority: each branch owns every stall/flush it raises.
    if (mem_wait) begin
      f_stall     = 1'b1;
      d_ctl.stall = 1'b1;
      e_ctl.stall = 1'b1;
      m_ctl.stall = 1'b1;
      w_flush     = 1'b1;
    end else if (md_op & ~done_now) begin
      f_stall     = 1'b1;
      d_ctl.stall = 1'b1;
      e_ctl.stall = 1'b1;
      m_ctl.flush = 1'b1;
    end else begin
      redir = e_valid & e_redirect;
      if (redir) begin
        d_ctl.flush = 1'b1;
        e_ctl.flush = 1'b1;
      end else if (load_use) begin
        f_stall     = 1'b1;
        d_ctl.stall = 1'b1;
        e_ctl.flush = 1'b1;
      end else if (fetch_wait | drop_hit) begin
        d_ctl.flush = 1'b1;
      end
    end

    state_next = state;
    pend_next  = md_done_pend;
    drop_upd   = drop_next;

    case (state)
      RUN:     if (md_launch & ~lat_one) state_next = MD_BUSY;
      MD_BUSY: if (timer_zero) begin
                 state_next = RUN;
                 pend_next  = 1'b1;
               end
      default: state_next = RUN;
    endcase

    if (md_done_pend & ~e_ctl.stall) pend_next = 1'b0;
    if (md_launch & lat_one & e_ctl.stall) pend_next = 1'b1;

    // A fetch in flight when the PC is rewritten returns a stale instruction.
    if (redir & fetch_wait) drop_upd = 1'b1;
    else if (drop_hit & ~d_ctl.stall) drop_upd = 1'b0;
  end

  assign md_start    = md_launch & ~reset;
  assign md_done     = done_now & ~reset;
  assign stall_f     = f_stall & ~reset;
  assign stall_d     = d_ctl.stall & ~reset;
  assign stall_e     = e_ctl.stall & ~reset;
  assign stall_m     = m_ctl.stall & ~reset;
  assign flush_d     = d_ctl.flush & ~reset;
  assign flush_e     = e_ctl.flush & ~reset;
  assign flush_m     = m_ctl.flush & ~reset;
  assign flush_w     = w_flush & ~reset;
  assign redirect_ok = redir & ~reset;

endmodule
